// File: rtl/mouse_cursor_tracker.sv
// Tracks the USB mouse report: clamped cursor published once per frame, and
// left-button presses over the chessboard converted to cell coordinates.
module mouse_cursor_tracker #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BOARD_X0    = 80,
   parameter int BOARD_Y0    = 0,
   parameter int CELL        = 60,
   parameter int DELTA_SHIFT = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] report,
   input  logic        vsync,
   output logic [9:0]  cursor_x,
   output logic [9:0]  cursor_y,
   output logic        left_btn,
   output logic        right_btn,
   output logic        click_valid,
   input  logic        click_ready,
   output logic [2:0]  click_col,
   output logic [2:0]  click_row,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, DIV, PRESENT} state_t;

   localparam logic signed [11:0] MAX_X  = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] MAX_Y  = 12'(SCREEN_H - 1);
   localparam logic [9:0]         HOME_X = 10'(SCREEN_W / 2);
   localparam logic [9:0]         HOME_Y = 10'(SCREEN_H / 2);
   localparam logic [9:0]         X_LO   = 10'(BOARD_X0);
   localparam logic [9:0]         Y_LO   = 10'(BOARD_Y0);
   localparam logic [10:0]        SPAN   = 11'(8 * CELL);
   localparam logic [9:0]         CELL_V = 10'(CELL);

   logic [31:0] report_q;
   logic        vs_q;
   state_t      state_q, state_d;
   logic        prime_q, prime_d;
   logic [7:0]  last_seq_q, last_seq_d;
   logic [9:0]  int_x_q, int_x_d, int_y_q, int_y_d;
   logic [9:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic        left_q, left_d, right_q, right_d;
   logic        press_q, press_d;
   logic [2:0]  div_cnt_q, div_cnt_d;
   logic [9:0]  rel_x_q, rel_x_d, rel_y_q, rel_y_d;
   logic [2:0]  col_q, col_d, row_q, row_d;
   logic        ovr_q, ovr_d;

   logic signed [11:0] dx_ext, dy_ext, dx_s, dy_s, sum_x, sum_y;
   logic [9:0]         move_x, move_y;
   logic [10:0]        off_x, off_y;
   logic               on_board;
   logic               unused_bits;

   assign unused_bits = ^report_q[23:18];

   // Sign-extend the deltas to 12 bits so the sum can go negative before clamping.
   assign dx_ext = {{4{report_q[15]}}, report_q[15:8]};
   assign dy_ext = {{4{report_q[7]}}, report_q[7:0]};
   assign dx_s   = dx_ext >>> DELTA_SHIFT;
   assign dy_s   = dy_ext >>> DELTA_SHIFT;
   assign sum_x  = $signed({2'b00, int_x_q}) + dx_s;
   assign sum_y  = $signed({2'b00, int_y_q}) + dy_s;
   assign move_x = (sum_x < 12'sd0) ? 10'd0 : (sum_x > MAX_X) ? MAX_X[9:0] : sum_x[9:0];
   assign move_y = (sum_y < 12'sd0) ? 10'd0 : (sum_y > MAX_Y) ? MAX_Y[9:0] : sum_y[9:0];

   // A position left of/above the board wraps the offset past SPAN, so one compare covers both edges.
   assign off_x    = {1'b0, int_x_q} - {1'b0, X_LO};
   assign off_y    = {1'b0, int_y_q} - {1'b0, Y_LO};
   assign on_board = (off_x < SPAN) && (off_y < SPAN);

   always_comb begin
      state_d    = state_q;
      prime_d    = prime_q;
      last_seq_d = last_seq_q;
      int_x_d    = int_x_q;
      int_y_d    = int_y_q;
      cur_x_d    = cur_x_q;
      cur_y_d    = cur_y_q;
      left_d     = left_q;
      right_d    = right_q;
      press_d    = 1'b0;
      div_cnt_d  = div_cnt_q;
      rel_x_d    = rel_x_q;
      rel_y_d    = rel_y_q;
      col_d      = col_q;
      row_d      = row_q;
      ovr_d      = ovr_q;

      if (prime_q) begin
         last_seq_d = report_q[31:24];
         left_d     = report_q[16];
         right_d    = report_q[17];
         prime_d    = 1'b0;
      end else if (report_q[31:24] != last_seq_q) begin
         last_seq_d = report_q[31:24];
         int_x_d    = move_x;
         int_y_d    = move_y;
         left_d     = report_q[16];
         right_d    = report_q[17];
         press_d    = report_q[16] & ~left_q;
      end

      if (vsync & ~vs_q) begin
         cur_x_d = int_x_q;
         cur_y_d = int_y_q;
      end

      // press_q is one edge old, so int_x_q/int_y_q already hold the post-move position.
      unique case (state_q)
         IDLE: begin
            if (press_q && on_board) begin
               state_d   = DIV;
               rel_x_d   = off_x[9:0];
               rel_y_d   = off_y[9:0];
               col_d     = 3'd0;
               row_d     = 3'd0;
               div_cnt_d = 3'd0;
            end
         end
         DIV: begin
            if (rel_x_q >= CELL_V) begin
               rel_x_d = rel_x_q - CELL_V;
               col_d   = col_q + 3'd1;
            end
            if (rel_y_q >= CELL_V) begin
               rel_y_d = rel_y_q - CELL_V;
               row_d   = row_q + 3'd1;
            end
            div_cnt_d = div_cnt_q + 3'd1;
            if (div_cnt_q == 3'd7) state_d = PRESENT;
            if (press_q) ovr_d = 1'b1;
         end
         PRESENT: begin
            if (click_ready) state_d = IDLE;
            if (press_q) ovr_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      report_q <= report;
      vs_q     <= vsync;
      if (Reset) begin
         state_q    <= IDLE;
         prime_q    <= 1'b1;
         last_seq_q <= 8'd0;
         int_x_q    <= HOME_X;
         int_y_q    <= HOME_Y;
         cur_x_q    <= HOME_X;
         cur_y_q    <= HOME_Y;
         left_q     <= 1'b0;
         right_q    <= 1'b0;
         press_q    <= 1'b0;
         div_cnt_q  <= 3'd0;
         rel_x_q    <= 10'd0;
         rel_y_q    <= 10'd0;
         col_q      <= 3'd0;
         row_q      <= 3'd0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prime_q    <= prime_d;
         last_seq_q <= last_seq_d;
         int_x_q    <= int_x_d;
         int_y_q    <= int_y_d;
         cur_x_q    <= cur_x_d;
         cur_y_q    <= cur_y_d;
         left_q     <= left_d;
         right_q    <= right_d;
         press_q    <= press_d;
         div_cnt_q  <= div_cnt_d;
         rel_x_q    <= rel_x_d;
         rel_y_q    <= rel_y_d;
         col_q      <= col_d;
         row_q      <= row_d;
         ovr_q      <= ovr_d;
      end
   end

   assign cursor_x    = cur_x_q;
   assign cursor_y    = cur_y_q;
   assign left_btn    = left_q;
   assign right_btn   = right_q;
   assign click_valid = (state_q == PRESENT);
   assign click_col   = col_q;
   assign click_row   = row_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: movement table, click corner cases, and a
// random run checked every cycle against a behavioural model.
module tb_mouse_cursor_tracker;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] report = 32'd0;
   logic        vsync = 1'b0;
   logic        click_ready = 1'b0;
   logic [9:0]  cursor_x, cursor_y;
   logic        left_btn, right_btn, click_valid, overrun;
   logic [2:0]  click_col, click_row;

   int n_cmp = 0;
   int n_bad = 0;

   mouse_cursor_tracker dut (
      .Clk(Clk), .Reset(Reset), .report(report), .vsync(vsync),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .left_btn(left_btn), .right_btn(right_btn),
      .click_valid(click_valid), .click_ready(click_ready),
      .click_col(click_col), .click_row(click_row), .overrun(overrun)
   );

   always #5 Clk = ~Clk;

   // Behavioural model: positions as integers, cell via division, click as
   // a busy flag plus the cycle at which it became pending.
   logic [31:0] m_rep_q = 32'd0;
   bit m_vs_q = 0, m_prime = 1, m_l = 0, m_r = 0, m_press = 0;
   bit m_busy = 0, m_valid = 0, m_ovr = 0;
   int m_seq = 0, m_x = 320, m_y = 240, m_cx = 320, m_cy = 240;
   int m_start = 0, m_col = 0, m_row = 0, cyc = 0;
   int seq_c = 0;

   typedef struct {
      int seq; int btn; int dx; int dy; int ex; int ey; int er;
   } vec_t;
   vec_t vecs [12];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int ox, oy, dx, dy, nx, ny;
      bit opress, obusy, ovalid, npress;
      cyc++;
      if (Reset) begin
         m_prime = 1; m_seq = 0; m_x = 320; m_y = 240; m_cx = 320; m_cy = 240;
         m_l = 0; m_r = 0; m_press = 0; m_busy = 0; m_valid = 0; m_ovr = 0;
         m_col = 0; m_row = 0;
      end else begin
         ox = m_x; oy = m_y; opress = m_press; obusy = m_busy; ovalid = m_valid;
         npress = 0;
         if (m_prime) begin
            m_seq = int'(m_rep_q[31:24]); m_l = m_rep_q[16]; m_r = m_rep_q[17];
            m_prime = 0;
         end else if (int'(m_rep_q[31:24]) != m_seq) begin
            dx = int'($signed(m_rep_q[15:8]));
            dy = int'($signed(m_rep_q[7:0]));
            nx = ox + dx; if (nx < 0) nx = 0; if (nx > 639) nx = 639;
            ny = oy + dy; if (ny < 0) ny = 0; if (ny > 479) ny = 479;
            npress = m_rep_q[16] && !m_l;
            m_seq = int'(m_rep_q[31:24]); m_l = m_rep_q[16]; m_r = m_rep_q[17];
            m_x = nx; m_y = ny;
         end
         if (vsync && !m_vs_q) begin m_cx = ox; m_cy = oy; end
         if (ovalid && click_ready) m_busy = 0;
         if (opress) begin
            if (obusy) m_ovr = 1;
            else if (ox >= 80 && ox < 560 && oy < 480) begin
               m_busy = 1; m_start = cyc;
               m_col = (ox - 80) / 60; m_row = oy / 60;
            end
         end
         m_press = npress;
         m_valid = m_busy && (cyc >= m_start + 8);
      end
      m_rep_q = report;
      m_vs_q  = vsync;
   endtask

   task automatic check_all();
      chk("cursor_x", int'(cursor_x), m_cx);
      chk("cursor_y", int'(cursor_y), m_cy);
      chk("left_btn", int'(left_btn), int'(m_l));
      chk("right_btn", int'(right_btn), int'(m_r));
      chk("click_valid", int'(click_valid), int'(m_valid));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (m_valid) begin
         chk("click_col", int'(click_col), m_col);
         chk("click_row", int'(click_row), m_row);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic send(input bit [1:0] btn, input int dx, input int dy);
      seq_c = (seq_c + 1) % 256;
      report = {8'(seq_c), 6'd0, btn, 8'(dx), 8'(dy)};
      tick();
      tick();
   endtask

   task automatic goto_xy(input int x, input int y);
      int dx, dy;
      for (int k = 0; k < 20 && (m_x != x || m_y != y); k++) begin
         dx = x - m_x; if (dx > 127) dx = 127; if (dx < -128) dx = -128;
         dy = y - m_y; if (dy > 127) dy = 127; if (dy < -128) dy = -128;
         send(2'b00, dx, dy);
      end
   endtask

   task automatic vs_pulse();
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
   endtask

   initial begin
      int n, px, py;
      bit seen;

      vecs[0]  = '{1,  0,   10,   -5, 330, 235, 0};
      vecs[1]  = '{1,  0,   50,    0, 330, 235, 0};
      vecs[2]  = '{2,  0, -128, -128, 202, 107, 0};
      vecs[3]  = '{3,  0, -128, -128,  74,   0, 0};
      vecs[4]  = '{4,  0, -128,  127,   0, 127, 0};
      vecs[5]  = '{5,  0, -128,  127,   0, 254, 0};
      vecs[6]  = '{6,  0,  127,  127, 127, 381, 0};
      vecs[7]  = '{7,  0,  127,  127, 254, 479, 0};
      vecs[8]  = '{8,  2,  127,    0, 381, 479, 1};
      vecs[9]  = '{9,  0,  127,   -1, 508, 478, 0};
      vecs[10] = '{10, 0,  127,    0, 635, 478, 0};
      vecs[11] = '{11, 0,  127,    0, 639, 478, 0};

      // Reset state
      repeat (3) tick();
      chk("rst_cursor_x", int'(cursor_x), 320);
      chk("rst_cursor_y", int'(cursor_y), 240);
      chk("rst_valid", int'(click_valid), 0);
      chk("rst_col", int'(click_col), 0);
      chk("rst_row", int'(click_row), 0);
      chk("rst_overrun", int'(overrun), 0);
      Reset = 1'b0;

      // Movement table: cursor holds until the vsync edge, then shows the clamped position
      px = 320; py = 240;
      for (int i = 0; i < 12; i++) begin
         seq_c  = vecs[i].seq;
         report = {8'(vecs[i].seq), 6'd0, 2'(vecs[i].btn), 8'(vecs[i].dx), 8'(vecs[i].dy)};
         repeat (3) tick();
         chk($sformatf("vec%0d_pre_x", i), int'(cursor_x), px);
         chk($sformatf("vec%0d_pre_y", i), int'(cursor_y), py);
         vs_pulse();
         chk($sformatf("vec%0d_x", i), int'(cursor_x), vecs[i].ex);
         chk($sformatf("vec%0d_y", i), int'(cursor_y), vecs[i].ey);
         chk($sformatf("vec%0d_right", i), int'(right_btn), vecs[i].er);
         $display("vec %0d: seq=%0d dx=%0d dy=%0d -> cursor (%0d,%0d)",
                  i, vecs[i].seq, vecs[i].dx, vecs[i].dy, cursor_x, cursor_y);
         px = vecs[i].ex; py = vecs[i].ey;
      end

      // On-board click: latency 9 edges after the update edge, cell (2,2)
      goto_xy(205, 130);
      click_ready = 1'b1;
      send(2'b01, 0, 0);
      n = 0;
      while (!click_valid && n < 20) begin tick(); n++; end
      chk("click_latency", n, 9);
      chk("click_col_a", int'(click_col), 2);
      chk("click_row_a", int'(click_row), 2);
      $display("click: latency=%0d col=%0d row=%0d", n, click_col, click_row);
      tick();
      chk("click_valid_drop", int'(click_valid), 0);
      send(2'b00, 0, 0);

      // Off-board presses at x=40 and x=560
      goto_xy(40, 130);
      send(2'b01, 0, 0);
      seen = 0;
      repeat (15) begin tick(); if (click_valid) seen = 1; end
      chk("offboard40_valid", int'(seen), 0);
      chk("offboard40_ovr", int'(overrun), 0);
      send(2'b00, 0, 0);
      goto_xy(560, 130);
      send(2'b01, 0, 0);
      seen = 0;
      repeat (15) begin tick(); if (click_valid) seen = 1; end
      chk("offboard560_valid", int'(seen), 0);
      chk("offboard560_ovr", int'(overrun), 0);
      send(2'b00, 0, 0);
      $display("offboard: overrun=%0d", overrun);

      // Held PRESENT: second press is dropped, cell stays, single transfer
      click_ready = 1'b0;
      goto_xy(205, 130);
      send(2'b01, 0, 0);
      n = 0;
      while (!click_valid && n < 20) begin tick(); n++; end
      chk("hold_valid", int'(click_valid), 1);
      send(2'b00, 0, 0);
      send(2'b01, 0, 0);
      repeat (3) tick();
      chk("hold_overrun", int'(overrun), 1);
      chk("hold_valid2", int'(click_valid), 1);
      chk("hold_col", int'(click_col), 2);
      chk("hold_row", int'(click_row), 2);
      click_ready = 1'b1;
      tick();
      chk("hold_xfer_drop", int'(click_valid), 0);
      seen = 0;
      repeat (12) begin tick(); if (click_valid) seen = 1; end
      chk("hold_single_xfer", int'(seen), 0);
      chk("hold_ovr_sticky", int'(overrun), 1);
      $display("hold: overrun=%0d after transfer", overrun);
      send(2'b00, 0, 0);

      // Reset during DIV, then the first post-reset report must not move the cursor
      send(2'b01, 0, 0);
      repeat (3) tick();
      Reset = 1'b1;
      seq_c = (seq_c + 1) % 256;
      report = {8'(seq_c), 6'd0, 2'b00, 8'd7, 8'd7};
      tick();
      chk("midrst_valid", int'(click_valid), 0);
      chk("midrst_x", int'(cursor_x), 320);
      chk("midrst_y", int'(cursor_y), 240);
      chk("midrst_ovr", int'(overrun), 0);
      chk("midrst_left", int'(left_btn), 0);
      tick();
      Reset = 1'b0;
      repeat (3) tick();
      vs_pulse();
      chk("postrst_x", int'(cursor_x), 320);
      chk("postrst_y", int'(cursor_y), 240);
      send(2'b00, 5, 0);
      vs_pulse();
      chk("postrst_move_x", int'(cursor_x), 325);
      chk("postrst_move_y", int'(cursor_y), 240);
      $display("midreset: cursor (%0d,%0d)", cursor_x, cursor_y);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 4) != 0) seq_c = (seq_c + 1) % 256;
            report = {8'(seq_c), 6'd0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom)};
         end
         if ($urandom_range(0, 9) == 0) vsync = ~vsync;
         click_ready = ($urandom_range(0, 2) != 0);
         Reset = ($urandom_range(0, 599) == 0);
         tick();
      end
      Reset = 1'b0;
      tick();
      $display("random: %0d cycles done", 3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
